// File: rtl/pkg_defs.sv
// Shared constants for the package sink: header sync byte, parameter defaults,
// FSM encoding and the header layout.
package pkg_defs;

    localparam int unsigned AW_DEF     = 6;
    localparam logic [7:0]  SYNC_DEF   = 8'hA5;
    localparam int unsigned TMO_US_DEF = 100;

    localparam int unsigned SW = 2;
    localparam logic [SW-1:0] ST_IDLE = 2'd0;
    localparam logic [SW-1:0] ST_RECV = 2'd1;
    localparam logic [SW-1:0] ST_DROP = 2'd2;
    localparam logic [SW-1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic [7:0] sync;
        logic [7:0] len;
    } hdr_t;

    // A header is usable when the sync byte matches and it announces a payload.
    function automatic logic hdr_ok(input hdr_t h, input logic [7:0] sync);
        return (h.sync == sync) && (h.len != 8'd0);
    endfunction

endpackage

// File: rtl/pkg_fifo.sv
// Word FIFO with a commit point: writes stay invisible to the reader until
// committed, and an aborted package is discarded by rewinding to the commit point.
module pkg_fifo
    import pkg_defs::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [15:0]   wr_d,
    input  logic          commit,
    input  logic          rewind,
    input  logic          rd_en,
    input  logic          peek,
    output logic [15:0]   rd_d_c,
    output logic          rd_ok_c,
    output logic [AW:0]   free_c
);

    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] commit_rd;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_addr;

    // commit_rd delays the commit point seen by the reader by one cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            commit_rd  <= '0;
            rd_ptr     <= '0;
        end else begin
            if (rewind) begin
                wr_ptr <= commit_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                commit_ptr <= wr_ptr;
            end
            commit_rd <= commit_ptr;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_d;
        end
    end

    // peek looks one word ahead while the current word is being retired.
    assign rd_addr = rd_ptr + PW'(peek);
    assign rd_d_c  = mem[rd_addr[AW-1:0]];
    assign rd_ok_c = (rd_addr != commit_rd);
    assign free_c  = PW'(DEPTH) - (wr_ptr - rd_ptr);

endmodule

// File: rtl/pkg_sink.sv
// Receiving end of the package interface: header check, commit/rewind buffering,
// pkg_done acknowledge, byte serializer toward the host link, and statistics.
module pkg_sink
    import pkg_defs::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter logic [7:0]  SYNC   = SYNC_DEF,
    parameter int unsigned TMO_US = TMO_US_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pluse_us,
    input  logic [15:0] pkg_d,
    input  logic        pkg_vld,
    output logic        pkg_done,
    output logic [7:0]  tx_d,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [15:0] pkg_cnt,
    output logic [7:0]  drop_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TW = $clog2(TMO_US + 1);
    localparam int unsigned CW = (AW + 1 > 9) ? AW + 1 : 9;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_US - 1);

    logic [SW-1:0] state, state_nxt;
    logic [7:0]    rem, rem_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic          commit_pend, commit_pend_nxt;

    logic          wr_en_c, rewind_c, commit_c;
    logic          pkg_inc_c, drop_inc_c, err_inc_c;
    logic          tmo_hit_c;
    logic          ld_c, rd_en_c;
    logic          tx_lo;
    hdr_t          hdr_c;
    logic [15:0]   rd_d_c;
    logic          rd_ok_c;
    logic [AW:0]   free_c;

    assign hdr_c     = hdr_t'(pkg_d);
    assign tmo_hit_c = pluse_us && (tmo == TMO_LAST);

    pkg_fifo #(.AW(AW)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_d    (pkg_d),
        .commit  (commit_c),
        .rewind  (rewind_c),
        .rd_en   (rd_en_c),
        .peek    (rd_en_c),
        .rd_d_c  (rd_d_c),
        .rd_ok_c (rd_ok_c),
        .free_c  (free_c)
    );

    // Next-state logic; an incoming word takes priority over a timeout hit.
    always_comb begin
        state_nxt       = state;
        rem_nxt         = rem;
        tmo_nxt         = tmo;
        commit_pend_nxt = commit_pend;
        wr_en_c         = 1'b0;
        rewind_c        = 1'b0;
        commit_c        = 1'b0;
        pkg_inc_c       = 1'b0;
        drop_inc_c      = 1'b0;
        err_inc_c       = 1'b0;
        case (state)
            ST_IDLE: begin
                tmo_nxt         = '0;
                commit_pend_nxt = 1'b0;
                if (pkg_vld) begin
                    if (!hdr_ok(hdr_c, SYNC)) begin
                        err_inc_c = 1'b1;
                    end else if (CW'(hdr_c.len) + CW'(1) > CW'(free_c)) begin
                        state_nxt  = ST_DROP;
                        rem_nxt    = hdr_c.len;
                        drop_inc_c = 1'b1;
                    end else begin
                        wr_en_c   = 1'b1;
                        state_nxt = ST_RECV;
                        rem_nxt   = hdr_c.len;
                    end
                end
            end
            ST_RECV, ST_DROP: begin
                if (pkg_vld) begin
                    wr_en_c = (state == ST_RECV);
                    rem_nxt = rem - 8'd1;
                    tmo_nxt = '0;
                    if (rem == 8'd1) begin
                        state_nxt       = ST_DONE;
                        commit_pend_nxt = (state == ST_RECV);
                    end
                end else if (tmo_hit_c) begin
                    rewind_c  = 1'b1;
                    err_inc_c = 1'b1;
                    tmo_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (pluse_us) begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            ST_DONE: begin
                commit_c  = commit_pend;
                pkg_inc_c = commit_pend;
                err_inc_c = pkg_vld;
                tmo_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rem         <= '0;
            tmo         <= '0;
            commit_pend <= 1'b0;
            pkg_done    <= 1'b0;
            pkg_cnt     <= '0;
            drop_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            rem         <= rem_nxt;
            tmo         <= tmo_nxt;
            commit_pend <= commit_pend_nxt;
            pkg_done    <= (state_nxt == ST_DONE);
            if (pkg_inc_c && (pkg_cnt != '1)) begin
                pkg_cnt <= pkg_cnt + 16'd1;
            end
            if (drop_inc_c && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (err_inc_c && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Serializer: high byte then low byte; retiring the low byte advances rd_ptr.
    assign ld_c    = !tx_vld || tx_rdy;
    assign rd_en_c = tx_vld && tx_rdy && tx_lo;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tx_d   <= '0;
            tx_vld <= 1'b0;
            tx_lo  <= 1'b0;
        end else if (ld_c) begin
            if (tx_vld && !tx_lo) begin
                tx_d  <= rd_d_c[7:0];
                tx_lo <= 1'b1;
            end else if (rd_ok_c) begin
                tx_d   <= rd_d_c[15:8];
                tx_lo  <= 1'b0;
                tx_vld <= 1'b1;
            end else begin
                tx_vld <= 1'b0;
                tx_lo  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pkg_sink.sv
// Directed bench for pkg_sink: expected tx bytes are queued as packages are sent
// and checked by a monitor as the serializer hands them over.
module tb_pkg_sink;

    logic        clk_sys;
    logic        rst_n;
    logic        pluse_us;
    logic [15:0] pkg_d;
    logic        pkg_vld;
    logic        pkg_done;
    logic [7:0]  tx_d;
    logic        tx_vld;
    logic        tx_rdy;
    logic [15:0] pkg_cnt;
    logic [7:0]  drop_cnt;
    logic [7:0]  err_cnt;

    int n_vec = 0;
    int n_err = 0;
    int done_pulses = 0;
    int exp_done = 0;

    logic [7:0] exp_q [$];
    logic       prev_stall;
    logic [7:0] prev_d;

    pkg_sink dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (pluse_us),
        .pkg_d    (pkg_d),
        .pkg_vld  (pkg_vld),
        .pkg_done (pkg_done),
        .tx_d     (tx_d),
        .tx_vld   (tx_vld),
        .tx_rdy   (tx_rdy),
        .pkg_cnt  (pkg_cnt),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        pkg_d   = w;
        pkg_vld = 1'b1;
        cyc();
        pkg_vld = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            pluse_us = 1'b1;
            cyc();
            pluse_us = 1'b0;
            cyc();
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (4) cyc();
        chk({tag, "_quiet"}, 32'(tx_vld), 32'd0);
    endtask

    // Monitor sampled mid-low-phase: tx_rdy and tx_vld/tx_d here are the values
    // the next rising edge will act on.
    always @(negedge clk_sys) begin
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (pkg_done) done_pulses++;
            if (prev_stall) begin
                chk("tx_hold_vld", 32'(tx_vld), 32'd1);
                chk("tx_hold_d", 32'(tx_d), 32'(prev_d));
            end
            if (tx_vld && tx_rdy) begin
                if (exp_q.size() != 0) begin
                    chk("tx_byte", 32'(tx_d), 32'(exp_q.pop_front()));
                end else begin
                    chk("tx_byte_extra", 32'(tx_d), 32'h100);
                end
            end
            prev_stall = tx_vld && !tx_rdy;
            prev_d     = tx_d;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        pluse_us = 1'b0;
        pkg_d    = '0;
        pkg_vld  = 1'b0;
        tx_rdy   = 1'b1;
        cyc();
        cyc();
        chk("rst_done", 32'(pkg_done), 32'd0);
        chk("rst_tx_vld", 32'(tx_vld), 32'd0);
        chk("rst_tx_d", 32'(tx_d), 32'd0);
        chk("rst_pkg_cnt", 32'(pkg_cnt), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic package, streaming with tx_rdy high.
        push_word(16'hA502); push_word(16'h1111); push_word(16'h2222);
        send(16'hA502);
        send(16'h1111);
        chk("t1_done_early", 32'(pkg_done), 32'd0);
        send(16'h2222);
        chk("t1_done", 32'(pkg_done), 32'd1);
        exp_done++;
        cyc();
        chk("t1_done_pulse", 32'(pkg_done), 32'd0);
        drain("t1");
        chk("t1_pkg_cnt", 32'(pkg_cnt), 32'd1);

        // Bad sync is ignored and counted; next package goes through.
        send(16'h5A03);
        chk("t2_bad_nodone", 32'(pkg_done), 32'd0);
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        push_word(16'hA501); push_word(16'hBEEF);
        send(16'hA501);
        send(16'hBEEF);
        chk("t2_done", 32'(pkg_done), 32'd1);
        exp_done++;
        drain("t2");
        chk("t2_pkg_cnt", 32'(pkg_cnt), 32'd2);

        // Stalled output: tx_vld latency after commit, then a package too big to fit.
        tx_rdy = 1'b0;
        push_word(16'hA501); push_word(16'hBEEF);
        send(16'hA501);
        send(16'hBEEF);
        chk("t3_done", 32'(pkg_done), 32'd1);
        exp_done++;
        chk("t3_vld_lat0", 32'(tx_vld), 32'd0);
        cyc();
        chk("t3_vld_lat1", 32'(tx_vld), 32'd0);
        cyc();
        chk("t3_vld_lat2", 32'(tx_vld), 32'd0);
        cyc();
        chk("t3_vld_rise", 32'(tx_vld), 32'd1);
        chk("t3_first_byte", 32'(tx_d), 32'hA5);
        repeat (3) cyc();
        send(16'hA540);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 63; i++) send(16'(16'h0100 + i));
        chk("t3_drop_done_early", 32'(pkg_done), 32'd0);
        send(16'hFFFF);
        chk("t3_drop_done", 32'(pkg_done), 32'd1);
        exp_done++;
        chk("t3_hold_d", 32'(tx_d), 32'hA5);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        tx_rdy = 1'b1;
        drain("t3");
        chk("t3_pkg_cnt", 32'(pkg_cnt), 32'd3);

        // Inter-word timeout rewinds the partial package.
        send(16'hA504);
        send(16'h1111);
        send(16'h2222);
        pulses(99);
        chk("t4_err_before", 32'(err_cnt), 32'd1);
        pulses(1);
        chk("t4_err_after", 32'(err_cnt), 32'd2);
        repeat (4) cyc();
        chk("t4_no_tx", 32'(tx_vld), 32'd0);
        chk("t4_done_count", 32'(done_pulses), 32'(exp_done));
        push_word(16'hA502); push_word(16'h3333); push_word(16'h4444);
        send(16'hA502);
        send(16'h3333);
        send(16'h4444);
        chk("t4_done", 32'(pkg_done), 32'd1);
        exp_done++;
        drain("t4");
        chk("t4_pkg_cnt", 32'(pkg_cnt), 32'd4);

        // Word arriving together with the 100th microsecond strobe wins.
        push_word(16'hA502); push_word(16'h5555); push_word(16'h6666);
        send(16'hA502);
        send(16'h5555);
        pulses(99);
        pluse_us = 1'b1;
        send(16'h6666);
        pluse_us = 1'b0;
        chk("t5_done", 32'(pkg_done), 32'd1);
        exp_done++;
        chk("t5_err_cnt", 32'(err_cnt), 32'd2);
        drain("t5");
        chk("t5_pkg_cnt", 32'(pkg_cnt), 32'd5);
        chk("t5_done_count", 32'(done_pulses), 32'(exp_done));

        // Reset in the middle of a package.
        send(16'hA503);
        send(16'h7777);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_done", 32'(pkg_done), 32'd0);
        chk("t6_rst_tx_vld", 32'(tx_vld), 32'd0);
        chk("t6_rst_tx_d", 32'(tx_d), 32'd0);
        chk("t6_rst_pkg_cnt", 32'(pkg_cnt), 32'd0);
        chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        chk("t6_no_tx", 32'(tx_vld), 32'd0);
        chk("t6_done_count", 32'(done_pulses), 32'(exp_done));
        push_word(16'hA501); push_word(16'h0102);
        send(16'hA501);
        send(16'h0102);
        chk("t6_done", 32'(pkg_done), 32'd1);
        exp_done++;
        drain("t6");
        chk("t6_pkg_cnt", 32'(pkg_cnt), 32'd1);
        chk("t6_done_count_end", 32'(done_pulses), 32'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkg_sink.md
Name: pkg_sink

Overview:
- Receiving end of the 16-bit package interface (pkg_d / pkg_vld / pkg_done) driven by the package builder.
- Checks each package header, buffers whole packages in a word FIFO with commit/rewind, and acknowledges each package with pkg_done.
- Streams committed packages out as bytes on a ready/valid port toward the host-link transmitter.
- Keeps package, drop and error counters for the register block.

Parameters:
- AW, 6, FIFO address width; depth is 2^AW = 64 words.
- SYNC, 8'hA5, required header high byte.
- TMO_US, 100, maximum inter-word gap in microseconds before a package is aborted.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pluse_us  in  1  one-cycle strobe, once per microsecond
- pkg_d  in  16  package word
- pkg_vld  in  1  word strobe; one word per high cycle, no backpressure
- pkg_done  out  1  one-cycle acknowledge that a package has been fully consumed
- tx_d  out  8  output byte
- tx_vld  out  1  output byte valid
- tx_rdy  in  1  downstream ready
- pkg_cnt  out  16  committed packages, saturating
- drop_cnt  out  8  packages dropped for lack of space, saturating
- err_cnt  out  8  bad headers plus timeouts, saturating

Behaviour:
- Reset: all outputs 0; wr_ptr, commit_ptr and rd_ptr = 0; byte phase = high; state = IDLE; FIFO contents discarded. Reset mid-package loses the partial package silently; no pkg_done is issued.
- Header format: pkg_d[15:8] = SYNC; pkg_d[7:0] = LEN, the payload word count, 1..255. A stored package is the header plus LEN words.
- free = 2^AW − (wr_ptr − commit_ptr) − (commit_ptr − rd_ptr). Pointers are AW+1 bits so full and empty are distinguishable.
- FSM IDLE, word accepted:
  - Bad sync or LEN = 0: ignore the word, err_cnt +1, stay in IDLE.
  - Else if LEN+1 > free: go to DROP with remaining = LEN, drop_cnt +1.
  - Else: write the header, go to RECV with remaining = LEN.
- FSM RECV: each pkg_vld writes the word and decrements remaining. The last word (remaining = 1) goes to DONE.
- FSM DROP: each pkg_vld decrements remaining; nothing is written. The last word goes to DONE.
- FSM DONE: lasts one cycle.
  - pkg_done = 1.
  - If arriving from RECV: commit_ptr ← wr_ptr and pkg_cnt +1.
  - Returns to IDLE.
- pkg_done latency: exactly one cycle after the clock edge that accepts the last word. A pkg_vld in the DONE cycle is a source protocol violation; the word is ignored and err_cnt +1.
- Timeout:
  - In RECV or DROP, a microsecond counter clears on every accepted word and increments on pluse_us.
  - When it reaches TMO_US: wr_ptr ← commit_ptr (rewind), err_cnt +1, go to IDLE, no pkg_done.
  - If pkg_vld and the timeout hit fall in the same cycle, the word wins: it is accepted and the counter cleared.
  - The counter is idle and held at 0 in IDLE.
- Output side:
  - Data is available when rd_ptr ≠ commit_ptr. Uncommitted words are never emitted.
  - Each word is emitted as two bytes: [15:8] first, then [7:0]. The transfer occurs on tx_vld & tx_rdy; the second byte advances rd_ptr.
  - tx_d and tx_vld are registered. tx_d must hold stable while tx_vld & !tx_rdy.
  - tx_vld rises exactly 2 cycles after the commit edge when the FIFO was previously empty.
  - Back-to-back transfers at one byte per cycle are required while tx_rdy = 1.
- A simultaneous commit and read does not disturb rd_ptr. Reads and writes of the same address cannot collide, because only committed addresses are read.
- Counters saturate at all-ones.

Decomposition:
- Shared package pkg_defs: SYNC, TMO_US default, state encoding (IDLE, RECV, DROP, DONE), AW default.
- Sub-module pkg_fifo: dual-port word RAM with wr_ptr, commit_ptr, rd_ptr, commit and rewind inputs, and free and avail outputs. pkg_sink holds the FSM, timeout, counters and byte serializer.

Test Plan:
- Header A502, words 1111 and 2222, tx_rdy=1 -> pkg_done 1 cycle after 2222; tx bytes A5 02 11 11 22 22; pkg_cnt = 1.
- Header 5A03 -> ignored; err_cnt = 1; following A501, BEEF -> accepted normally with pkg_done, then bytes A5 01 BE EF.
- Header A501, BEEF with tx_rdy held 0 -> tx_vld rises 2 cycles after commit and tx_d holds A5 until tx_rdy=1. Then, with tx_rdy still 0, header A540 (LEN = 64, needs 65 words > 62 free) plus its 64 words -> drop_cnt = 1, pkg_done pulses after the 64th word, nothing written, and only the first package is emitted once tx_rdy=1.
- Header A504, 2 words, then silence for 100 pluse_us -> err_cnt +1, no pkg_done, no tx output; next valid package is emitted intact.
- pkg_vld coincident with the 100th pluse_us -> word accepted, no timeout.
- rst_n low mid-RECV -> all outputs 0 asynchronously; no tx output from the partial package after release.
